// File: rtl/vfd_heartbeat.sv
// Free-running double-blink heartbeat LED: blink, gap, blink, long pause, once per period.
// o_led is registered one cycle behind the ms count; no inputs besides clock and reset, so no flow control.
module vfd_heartbeat #(
  parameter int unsigned f_clkin   = 12_000_000,
  parameter int unsigned period_ms = 1000,
  parameter int unsigned pulse_ms  = 100,
  parameter int unsigned gap_ms    = 100
) (
  input  logic clk,
  input  logic rst,
  output logic o_led
);

  localparam int unsigned DIV       = f_clkin / 1000;
  localparam int unsigned PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned MW        = (period_ms > 1) ? $clog2(period_ms) : 1;
  localparam int unsigned ON2_START = pulse_ms + gap_ms;
  localparam int unsigned ON2_END   = 2 * pulse_ms + gap_ms;

  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
  localparam logic [MW-1:0] MS_LAST  = MW'(period_ms - 1);

  if ((ON2_END > period_ms) || (f_clkin < 1000)) begin : g_bad_params
    $error("vfd_heartbeat: 2*pulse_ms+gap_ms must not exceed period_ms and f_clkin must be >= 1000");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [MW-1:0] ms_q, ms_d;
  logic          led_q, led_d;
  logic          tick;
  logic [31:0]   ms_ext;

  assign ms_ext = 32'(ms_q);

  always_comb begin
    presc_d = presc_q;
    ms_d    = ms_q;
    led_d   = 1'b0;
    tick    = (presc_q == DIV_LAST);

    if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (tick) begin
      if (ms_q == MS_LAST) begin
        ms_d = '0;
      end else begin
        ms_d = ms_q + MW'(1);
      end
    end

    // Pattern uses the ms count held before the edge, giving the one-cycle LED latency.
    led_d = (ms_ext < pulse_ms) || ((ms_ext >= ON2_START) && (ms_ext < ON2_END));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      ms_q    <= '0;
      led_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      ms_q    <= ms_d;
      led_q   <= led_d;
    end
  end

  assign o_led = led_q;

endmodule

// File: tb/tb_vfd_heartbeat.sv
// Heartbeat bench: two parameter sets driven from one clock and reset, checked per edge against an arithmetic model.
module tb_vfd_heartbeat;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic led_a;
  logic led_b;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  always #5 clk = ~clk;

  vfd_heartbeat #(
    .f_clkin  (12_000),
    .period_ms(1000),
    .pulse_ms (100),
    .gap_ms   (100)
  ) u_dut_a (
    .clk  (clk),
    .rst  (rst),
    .o_led(led_a)
  );

  vfd_heartbeat #(
    .f_clkin  (1000),
    .period_ms(10),
    .pulse_ms (2),
    .gap_ms   (1)
  ) u_dut_b (
    .clk  (clk),
    .rst  (rst),
    .o_led(led_b)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d t=%0t got=%0b exp=%0b", tag, k, $time, obs, exp);
    end
  endtask

  // k = rising edges since reset release; the LED after edge k shows ms value (k-1)/N.
  function automatic logic model_led(input int unsigned kk, input int unsigned n,
                                     input int unsigned per, input int unsigned pul,
                                     input int unsigned gap);
    int unsigned m;
    if (kk == 0) return 1'b0;
    m = ((kk - 1) / n) % per;
    return (m < pul) || ((m >= pul + gap) && (m < 2 * pul + gap));
  endfunction

  task automatic run_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      k++;
      chk("led_a", led_a, model_led(k, 12, 1000, 100, 100));
      chk("led_b", led_b, model_led(k, 1, 10, 2, 1));
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    k   = 0;
  endtask

  // Assert reset asynchronously partway through a cycle and hold it a few edges.
  task automatic mid_reset();
    int hold;
    #($urandom_range(1, 6));
    rst = 1'b0;
    #1;
    chk("async_rst_a", led_a, 1'b0);
    chk("async_rst_b", led_b, 1'b0);
    hold = $urandom_range(1, 5);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_rst_a", led_a, 1'b0);
      chk("hold_rst_b", led_b, 1'b0);
    end
    release_rst();
  endtask

  initial begin
    #3;
    chk("reset_a", led_a, 1'b0);
    chk("reset_b", led_b, 1'b0);
    repeat ($urandom_range(2, 4)) @(posedge clk);
    #1;
    chk("reset_hold_a", led_a, 1'b0);
    chk("reset_hold_b", led_b, 1'b0);

    release_rst();
    run_edges(25_000);

    // Reset during blink 2 of the slow instance (edge 2500).
    mid_reset();
    run_edges(2500);
    chk("edge2500_a", led_a, 1'b1);
    mid_reset();
    run_edges(4000);

    for (int r = 0; r < 3; r++) begin
      mid_reset();
      run_edges($urandom_range(100, 6000));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
